// File: rtl/sieve_pkg.sv
// sieve_pkg: shared types and constants for the prime-bitmap sieve sequencer.
//   sieve_state_e  : sequencer states (also exported on the debug state port)
//   BIT_COMPOSITE  : bitmap value for a non-prime address
//   BIT_PRIME      : bitmap value for a prime address
//   *_DEF          : default bitmap geometry and RAM read latency
package sieve_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CLEAR     = 3'd1,
      MARK      = 3'd2,
      SEEK_RD   = 3'd3,
      SEEK_WAIT = 3'd4,
      SEEK_CHK  = 3'd5,
      DONE      = 3'd6
   } sieve_state_e;

   localparam logic BIT_COMPOSITE = 1'b1;
   localparam logic BIT_PRIME     = 1'b0;

   localparam int N_MAX_DEF      = 1000000;
   localparam int ADDR_W_DEF     = 20;
   localparam int SQRT_LIMIT_DEF = 1000;
   localparam int RD_LAT_DEF     = 2;

endpackage

// File: rtl/sieve_ctrl_rd_valid_pipe.sv
// rd_valid_pipe: DEPTH-stage shift register tracking outstanding RAM reads.
//   clk, rstn  : clock, asynchronous active-low reset
//   flush      : synchronous clear of every stage (wins over valid_in)
//   valid_in   : a read was issued this cycle
//   pre_valid  : read data will be on the RAM output next cycle
//   valid_out  : read data is on the RAM output this cycle
// DEPTH must be at least 2 so that a one-cycle-early tap exists.
module rd_valid_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic flush,
   input  logic valid_in,
   output logic pre_valid,
   output logic valid_out
);

   logic [DEPTH-1:0] stage_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stage_q <= '0;
      end else if (flush) begin
         stage_q <= '0;
      end else begin
         stage_q <= {stage_q[DEPTH-2:0], valid_in};
      end
   end

   assign pre_valid = stage_q[DEPTH-2];
   assign valid_out = stage_q[DEPTH-1];

endmodule

// File: rtl/sieve_ctrl.sv
// sieve_ctrl: Eratosthenes sieve sequencer for a 1-bit prime-bitmap RAM.
//   clk, rstn                 : clock, asynchronous active-low reset
//   start                     : one-cycle pulse, starts a run from IDLE or DONE
//   busy / done               : run in progress / bitmap complete
//   cur_prime                 : prime being marked; ends at the last seek address
//   ram_wr_*                  : RAM port A (writes, 1 = composite)
//   ram_rd_en/addr/data       : RAM port B (reads, RD_LAT cycles en -> data)
//   disp_req/addr             : display read request, honoured only in DONE
//   disp_gnt/data/valid       : display owns port B / returned read data
//   dbg_state                 : current sequencer state (sieve_state_e encoding)
//
// Display handshake: there is no back-pressure. Every cycle with disp_gnt and
// disp_req high is an accepted request; its disp_valid/disp_data appear exactly
// RD_LAT cycles later, one per request, in request order.
module sieve_ctrl
   import sieve_pkg::*;
#(
   parameter int N_MAX      = N_MAX_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int SQRT_LIMIT = SQRT_LIMIT_DEF,
   parameter int RD_LAT     = RD_LAT_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_prime,
   output logic              ram_wr_en,
   output logic              ram_wr_we,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic              ram_wr_data,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic              ram_rd_data,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_data,
   output logic              disp_valid,
   output logic [2:0]        dbg_state
);

   // m carries one extra bit so m + p can run past N_MAX without wrapping.
   localparam logic [ADDR_W:0]   M_END   = (ADDR_W+1)'(N_MAX);
   localparam logic [ADDR_W:0]   M_LAST  = (ADDR_W+1)'(N_MAX - 1);
   localparam logic [ADDR_W:0]   M_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   M_TWO   = (ADDR_W+1)'(2);
   localparam logic [ADDR_W:0]   M_FOUR  = (ADDR_W+1)'(4);
   localparam logic [ADDR_W-1:0] P_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] P_TWO   = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] P_LIMIT = ADDR_W'(SQRT_LIMIT);

   sieve_state_e      state_q, state_d;
   logic [ADDR_W:0]   m_q, m_d;
   logic [ADDR_W-1:0] p_q, p_d;
   logic [ADDR_W-1:0] cp_q, cp_d;
   logic              gnt_q;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_data;
   logic              seek_rd;
   logic              pipe_flush;
   logic              pipe_pre_valid;
   logic              pipe_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         m_q     <= '0;
         p_q     <= P_TWO;
         cp_q    <= P_TWO;
         gnt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         p_q     <= p_d;
         cp_q    <= cp_d;
         gnt_q   <= (state_d == DONE);
      end
   end

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      p_d        = p_q;
      cp_d       = cp_q;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = BIT_PRIME;
      seek_rd    = 1'b0;
      pipe_flush = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = '0;
               state_d = CLEAR;
            end
         end

         // m doubles as the clear address; 0 and 1 are not primes.
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = m_q[ADDR_W-1:0];
            wr_data = (m_q < M_TWO) ? BIT_COMPOSITE : BIT_PRIME;
            if (m_q == M_LAST) begin
               p_d     = P_TWO;
               m_d     = M_FOUR;
               state_d = MARK;
            end else begin
               m_d = m_q + M_ONE;
            end
         end

         MARK: begin
            if (m_q < M_END) begin
               wr_en   = 1'b1;
               wr_addr = m_q[ADDR_W-1:0];
               wr_data = BIT_COMPOSITE;
               m_d     = m_q + {1'b0, p_q};
            end else begin
               p_d     = p_q + P_ONE;
               state_d = SEEK_RD;
            end
         end

         // Past the square-root bound nothing is left to mark; the final
         // seek address is kept as cur_prime.
         SEEK_RD: begin
            if (p_q > P_LIMIT) begin
               cp_d    = p_q;
               state_d = DONE;
            end else begin
               seek_rd = 1'b1;
               state_d = SEEK_WAIT;
            end
         end

         // The read pipe tells us when the seek data lands next cycle.
         SEEK_WAIT: begin
            if (pipe_pre_valid) begin
               state_d = SEEK_CHK;
            end
         end

         SEEK_CHK: begin
            if (ram_rd_data == BIT_COMPOSITE) begin
               p_d     = p_q + P_ONE;
               state_d = SEEK_RD;
            end else begin
               cp_d    = p_q;
               m_d     = {p_q, 1'b0};
               state_d = MARK;
            end
         end

         DONE: begin
            if (start) begin
               m_d        = '0;
               pipe_flush = 1'b1;
               state_d    = CLEAR;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Port B belongs to the display only in DONE; otherwise only seek reads.
   assign ram_rd_en   = (state_q == DONE) ? disp_req  : seek_rd;
   assign ram_rd_addr = (state_q == DONE) ? disp_addr : (seek_rd ? p_q : '0);

   rd_valid_pipe #(
      .DEPTH (RD_LAT)
   ) u_rd_valid_pipe (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (pipe_flush),
      .valid_in  (ram_rd_en),
      .pre_valid (pipe_pre_valid),
      .valid_out (pipe_valid)
   );

   assign ram_wr_en   = wr_en;
   assign ram_wr_we   = wr_en;
   assign ram_wr_addr = wr_addr;
   assign ram_wr_data = wr_data;

   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign done       = (state_q == DONE);
   assign cur_prime  = cp_q;
   assign disp_gnt   = gnt_q;
   assign disp_valid = pipe_valid && (state_q == DONE);
   assign disp_data  = disp_valid && ram_rd_data;
   assign dbg_state  = state_q;

endmodule
